// File: rtl/one_to_four_demux_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : one_to_four_demux_reg                                      |
// | Description : Registered 1-to-4 demultiplexer with per-lane holding      |
// |               registers, valid/ready handshakes and round-robin routing. |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module one_to_four_demux_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [1:0]         sel_in,
  input  logic               mode_in,
  input  logic               valid_in,
  output logic               ready_out,
  output logic [4*WIDTH-1:0] lane_data_out,
  output logic [3:0]         lane_valid_out,
  input  logic [3:0]         lane_ready_in,
  output logic [1:0]         rr_ptr_out,
  output logic [CNT_W-1:0]   count_out
);

  logic [1:0]       r_rr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [3:0]       r_valid;
  logic [1:0]       w_target;
  logic             w_ready;
  logic             w_accept;

  assign w_target = mode_in ? r_rr_ptr : sel_in;
  // A lane that drains this cycle can take a new word at the same edge.
  assign w_ready  = ~rst_in & (~r_valid[w_target] | lane_ready_in[w_target]);
  assign w_accept = valid_in & w_ready;

  generate
    for (genvar k = 0; k < 4; k++) begin : g_lane
      logic [WIDTH-1:0] r_data;
      logic             w_load;

      assign w_load = w_accept & (w_target == 2'(k));

      // Load has priority over consume so a load+drain keeps the lane full.
      always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
          r_data     <= '0;
          r_valid[k] <= 1'b0;
        end else if (w_load) begin
          r_data     <= data_in;
          r_valid[k] <= 1'b1;
        end else if (r_valid[k] & lane_ready_in[k]) begin
          r_valid[k] <= 1'b0;
        end
      end

      assign lane_data_out[k*WIDTH +: WIDTH] = r_data;
    end
  endgenerate

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_rr_ptr <= '0;
      r_count  <= '0;
    end else if (w_accept) begin
      r_count <= r_count + 1'b1;
      if (mode_in) begin
        r_rr_ptr <= r_rr_ptr + 1'b1;
      end
    end
  end

  assign ready_out      = w_ready;
  assign lane_valid_out = r_valid;
  assign rr_ptr_out     = r_rr_ptr;
  assign count_out      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_one_to_four_demux_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_one_to_four_demux_reg                                   |
// | Description : Directed vector bench for one_to_four_demux_reg.           |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_one_to_four_demux_reg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;   // narrow counter so the wrap is reached quickly

  logic               clk_in = 1'b0;
  logic               rst_in = 1'b1;
  logic [WIDTH-1:0]   data_in = '0;
  logic [1:0]         sel_in = '0;
  logic               mode_in = 1'b0;
  logic               valid_in = 1'b0;
  logic               ready_out;
  logic [4*WIDTH-1:0] lane_data_out;
  logic [3:0]         lane_valid_out;
  logic [3:0]         lane_ready_in = '0;
  logic [1:0]         rr_ptr_out;
  logic [CNT_W-1:0]   count_out;

  int total = 0;
  int bad   = 0;

  one_to_four_demux_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .data_in        (data_in),
    .sel_in         (sel_in),
    .mode_in        (mode_in),
    .valid_in       (valid_in),
    .ready_out      (ready_out),
    .lane_data_out  (lane_data_out),
    .lane_valid_out (lane_valid_out),
    .lane_ready_in  (lane_ready_in),
    .rr_ptr_out     (rr_ptr_out),
    .count_out      (count_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic       valid;
    logic [7:0] data;
    logic [3:0] lr;
    logic       exp_ready;
    logic [3:0] exp_valid;
    logic [31:0] exp_data;
    int         exp_count;
    logic [1:0] exp_ptr;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(logic m, logic [1:0] s, logic v, logic [7:0] d, logic [3:0] lr,
                              logic er, logic [3:0] ev, logic [31:0] ed, int ec, logic [1:0] ep);
    vec_t r;
    r.mode = m; r.sel = s; r.valid = v; r.data = d; r.lr = lr;
    r.exp_ready = er; r.exp_valid = ev; r.exp_data = ed; r.exp_count = ec; r.exp_ptr = ep;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    logic [CNT_W-1:0] ec;

    //        mode sel v  data   lr       rdy valid    lane data     cnt ptr
    vecs[0]  = mk(0, 2, 1, 8'hA5, 4'b0000, 1, 4'b0100, 32'h00A50000, 1,  0);
    vecs[1]  = mk(0, 1, 1, 8'h3C, 4'b0000, 1, 4'b0110, 32'h00A53C00, 2,  0);
    vecs[2]  = mk(0, 1, 1, 8'h77, 4'b0000, 0, 4'b0110, 32'h00A53C00, 2,  0);
    vecs[3]  = mk(0, 0, 1, 8'h5A, 4'b0000, 1, 4'b0111, 32'h00A53C5A, 3,  0);
    vecs[4]  = mk(0, 3, 1, 8'h11, 4'b0000, 1, 4'b1111, 32'h11A53C5A, 4,  0);
    vecs[5]  = mk(0, 3, 1, 8'h22, 4'b1000, 1, 4'b1111, 32'h22A53C5A, 5,  0);
    vecs[6]  = mk(0, 0, 0, 8'hEE, 4'b1111, 1, 4'b0000, 32'h22A53C5A, 5,  0);
    vecs[7]  = mk(1, 0, 1, 8'h01, 4'b1111, 1, 4'b0001, 32'h22A53C01, 6,  1);
    vecs[8]  = mk(1, 3, 1, 8'h02, 4'b1111, 1, 4'b0010, 32'h22A50201, 7,  2);
    vecs[9]  = mk(1, 0, 1, 8'h03, 4'b1111, 1, 4'b0100, 32'h22030201, 8,  3);
    vecs[10] = mk(1, 1, 1, 8'h04, 4'b1111, 1, 4'b1000, 32'h04030201, 9,  0);
    vecs[11] = mk(1, 2, 1, 8'h05, 4'b1111, 1, 4'b0001, 32'h04030205, 10, 1);
    vecs[12] = mk(1, 0, 1, 8'h66, 4'b0000, 1, 4'b0011, 32'h04036605, 11, 2);
    vecs[13] = mk(0, 1, 1, 8'h99, 4'b0000, 0, 4'b0011, 32'h04036605, 11, 2);
    vecs[14] = mk(1, 0, 1, 8'h88, 4'b0000, 1, 4'b0111, 32'h04886605, 12, 3);
    vecs[15] = mk(1, 0, 1, 8'h44, 4'b0000, 1, 4'b1111, 32'h44886605, 13, 0);
    vecs[16] = mk(1, 2, 1, 8'h55, 4'b0000, 0, 4'b1111, 32'h44886605, 13, 0);
    vecs[17] = mk(1, 2, 1, 8'h55, 4'b0001, 1, 4'b1111, 32'h44886655, 14, 1);
    vecs[18] = mk(0, 0, 0, 8'h00, 4'b0101, 1, 4'b1010, 32'h44886655, 14, 1);
    vecs[19] = mk(0, 0, 1, 8'hAA, 4'b0000, 1, 4'b1011, 32'h448866AA, 15, 1);
    vecs[20] = mk(0, 2, 1, 8'hBB, 4'b0000, 1, 4'b1111, 32'h44BB66AA, 16, 1);

    // Reset held for three cycles with a word offered.
    valid_in = 1'b1;
    data_in  = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_ready", 64'(ready_out), 64'd0);
      chk("reset_valid", 64'(lane_valid_out), 64'd0);
    end
    chk("reset_count", 64'(count_out), 64'd0);
    chk("reset_ptr",   64'(rr_ptr_out), 64'd0);
    chk("reset_data",  64'(lane_data_out), 64'd0);
    valid_in = 1'b0;
    rst_in   = 1'b0;
    step();
    chk("post_reset_valid", 64'(lane_valid_out), 64'd0);
    chk("post_reset_count", 64'(count_out), 64'd0);

    for (int i = 0; i < 21; i++) begin
      mode_in       = vecs[i].mode;
      sel_in        = vecs[i].sel;
      valid_in      = vecs[i].valid;
      data_in       = vecs[i].data;
      lane_ready_in = vecs[i].lr;
      #1;
      chk($sformatf("v%0d_ready", i), 64'(ready_out), 64'(vecs[i].exp_ready));
      step();
      ec = CNT_W'(vecs[i].exp_count);
      chk($sformatf("v%0d_valid", i), 64'(lane_valid_out), 64'(vecs[i].exp_valid));
      chk($sformatf("v%0d_data", i),  64'(lane_data_out),  64'(vecs[i].exp_data));
      chk($sformatf("v%0d_count", i), 64'(count_out),      64'(ec));
      chk($sformatf("v%0d_ptr", i),   64'(rr_ptr_out),     64'(vecs[i].exp_ptr));
    end

    // Asynchronous reset mid-cycle with every lane holding a word.
    valid_in      = 1'b0;
    lane_ready_in = 4'b0000;
    #2;
    rst_in = 1'b1;
    #1;
    chk("async_rst_valid", 64'(lane_valid_out), 64'd0);
    chk("async_rst_data",  64'(lane_data_out), 64'd0);
    chk("async_rst_count", 64'(count_out), 64'd0);
    chk("async_rst_ptr",   64'(rr_ptr_out), 64'd0);
    chk("async_rst_ready", 64'(ready_out), 64'd0);
    step();
    rst_in = 1'b0;
    step();
    chk("after_rst_valid", 64'(lane_valid_out), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running expected done");
    $fatal(1);
  end

endmodule
`default_nettype wire
